// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus multiplexer: FSM state type,
// source slot indices and default geometry.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } bus_state_e;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_N_SRC = 24;
    localparam int unsigned DEFAULT_CNT_W = 8;

    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_R1     = 1;
    localparam int unsigned SRC_R2     = 2;
    localparam int unsigned SRC_R3     = 3;
    localparam int unsigned SRC_R4     = 4;
    localparam int unsigned SRC_R5     = 5;
    localparam int unsigned SRC_R6     = 6;
    localparam int unsigned SRC_R7     = 7;
    localparam int unsigned SRC_R8     = 8;
    localparam int unsigned SRC_R9     = 9;
    localparam int unsigned SRC_R10    = 10;
    localparam int unsigned SRC_R11    = 11;
    localparam int unsigned SRC_R12    = 12;
    localparam int unsigned SRC_R13    = 13;
    localparam int unsigned SRC_R14    = 14;
    localparam int unsigned SRC_R15    = 15;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHI    = 18;
    localparam int unsigned SRC_ZLO    = 19;
    localparam int unsigned SRC_PC     = 20;
    localparam int unsigned SRC_MDR    = 21;
    localparam int unsigned SRC_INPORT = 22;
    localparam int unsigned SRC_C      = 23;

    // Index width for n sources; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_mux_reg_if.sv
// Bus-side signal bundle of bus_mux_reg: source words/enables in, registered
// bus value and conflict diagnostics out.
interface bus_mux_reg_if
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N_SRC = DEFAULT_N_SRC,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);
    localparam int unsigned SEL_W = sel_width(N_SRC);

    logic [N_SRC*WIDTH-1:0] src_data;
    logic [N_SRC-1:0]       src_out;
    logic                   err_clr;
    logic [WIDTH-1:0]       bus_out;
    logic                   bus_valid;
    logic [SEL_W-1:0]       bus_sel;
    logic                   conflict;
    logic                   conflict_flag;
    logic [CNT_W-1:0]       conflict_cnt;

    modport master (
        output src_data, src_out, err_clr,
        input  bus_out, bus_valid, bus_sel, conflict, conflict_flag, conflict_cnt
    );

    modport slave (
        input  src_data, src_out, err_clr,
        output bus_out, bus_valid, bus_sel, conflict, conflict_flag, conflict_cnt
    );
endinterface

// File: rtl/bus_prio_enc.sv
// Highest-index-wins priority encoder with "any" and "more than one" flags.
module bus_prio_enc
    import bus_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N_SRC,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Later (higher) set bits overwrite earlier ones; clearing the lowest set
    // bit leaves something only when two or more bits were set.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = SEL_W'(i);
            end
        end
        any   = |req;
        multi = |(req & (req - N'(1)));
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus multiplexer with multi-driver conflict detection,
// a saturating conflict counter and a sticky FAULT state.
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N_SRC = DEFAULT_N_SRC,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input logic           clock,
    input logic           clear,
    bus_mux_reg_if.slave  bus
);
    localparam int unsigned SEL_W = sel_width(N_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SEL_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;
    logic [WIDTH-1:0] win_word;

    logic [WIDTH-1:0] bus_d,      bus_q;
    logic [SEL_W-1:0] sel_d,      sel_q;
    logic             valid_d,    valid_q;
    logic             conflict_d, conflict_q;
    logic [CNT_W-1:0] cnt_d,      cnt_q;
    bus_state_e       state_d,    state_q;

    bus_prio_enc #(.N(N_SRC)) u_enc (
        .req   (bus.src_out),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // Select the winning source word from the packed source vector.
    always_comb begin
        win_word = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (SEL_W'(i) == enc_idx) begin
                win_word = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next bus value, conflict counter and FSM state.
    always_comb begin
        bus_d      = enc_any ? win_word : bus_q;
        sel_d      = enc_any ? enc_idx : sel_q;
        valid_d    = enc_any;
        conflict_d = enc_multi;

        // A conflict in the same cycle as err_clr restarts the count at one.
        cnt_d = cnt_q;
        if (enc_multi && bus.err_clr) begin
            cnt_d = CNT_W'(1);
        end else if (enc_multi) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (bus.err_clr) begin
            cnt_d = '0;
        end

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enc_multi)    state_d = FAULT;
                else if (enc_any) state_d = DRIVE;
            end
            DRIVE: begin
                if (enc_multi)     state_d = FAULT;
                else if (!enc_any) state_d = IDLE;
            end
            FAULT: begin
                if (bus.err_clr && !enc_multi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers and FSM state; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_q      <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
        end else begin
            bus_q      <= bus_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign bus.bus_out       = bus_q;
    assign bus.bus_sel       = sel_q;
    assign bus.bus_valid     = valid_q;
    assign bus.conflict      = conflict_q;
    assign bus.conflict_cnt  = cnt_q;
    assign bus.conflict_flag = (state_q == FAULT);

endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: stimulus pushes the expected registered
// outputs for each driven cycle; the monitor pops and compares after each edge.
module tb_bus_mux_reg;
    import bus_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_SRC = 24;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [31:0] bus;
        logic [4:0]  sel;
        logic        valid;
        logic        conf;
        logic        flag;
        logic [7:0]  cnt;
    } exp_t;

    logic clock;
    logic clear;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    string name_q[$];

    bus_mux_reg_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .CNT_W(CNT_W)) bif ();

    bus_mux_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] slot_val(input int unsigned i);
        case (i)
            SRC_R3:  return 32'h0000_00A5;
            SRC_R4:  return 32'h4444_4444;
            SRC_PC:  return 32'h0000_0040;
            SRC_MDR: return 32'hDEAD_BEEF;
            default: return 32'h1000_0000 + i * 32'h111;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] b, input int unsigned s,
                                input logic v, input logic c, input logic f,
                                input int unsigned n);
        exp_t e;
        e.bus   = b;
        e.sel   = 5'(s);
        e.valid = v;
        e.conf  = c;
        e.flag  = f;
        e.cnt   = 8'(n);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic step(input logic [23:0] en, input logic eclr, input logic clr,
                        input exp_t e, input string nm);
        @(negedge clock);
        bif.src_out = en;
        bif.err_clr = eclr;
        clear       = clr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare registered outputs one time unit after each rising edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, ".bus_out"},   bif.bus_out,                 e.bus);
                chk({nm, ".bus_sel"},   32'(bif.bus_sel),            32'(e.sel));
                chk({nm, ".bus_valid"}, 32'(bif.bus_valid),          32'(e.valid));
                chk({nm, ".conflict"},  32'(bif.conflict),           32'(e.conf));
                chk({nm, ".flag"},      32'(bif.conflict_flag),      32'(e.flag));
                chk({nm, ".cnt"},       32'(bif.conflict_cnt),       32'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] cf;
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        bif.src_out = '0;
        bif.err_clr = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            bif.src_data[i*WIDTH +: WIDTH] = slot_val(i);
        end
        cf = (24'd1 << SRC_R4) | (24'd1 << SRC_MDR);

        // Reset, asserted together with a source enable to show clear overrides.
        step(24'd0, 1'b0, 1'b1, mk(32'h0, 0, 0, 0, 0, 0), "reset0");
        step(24'd1 << SRC_R3, 1'b1, 1'b1, mk(32'h0, 0, 0, 0, 0, 0), "reset1");

        // Single driver R3, then idle hold.
        step(24'd1 << SRC_R3, 1'b0, 1'b0, mk(32'hA5, 3, 1, 0, 0, 0), "r3_drive");
        for (int k = 0; k < 3; k++)
            step(24'd0, 1'b0, 1'b0, mk(32'hA5, 3, 0, 0, 0, 0), "r3_hold");

        // Single drivers at both ends of the index range and one in between.
        step(24'd1 << SRC_R0, 1'b0, 1'b0, mk(slot_val(SRC_R0), 0, 1, 0, 0, 0), "r0_drive");
        step(24'd1 << SRC_C,  1'b0, 1'b0, mk(slot_val(SRC_C), 23, 1, 0, 0, 0), "c_drive");
        step(24'd1 << SRC_HI, 1'b0, 1'b0, mk(slot_val(SRC_HI), 16, 1, 0, 0, 0), "hi_drive");

        // Conflict R4 + MDR: MDR wins, one-cycle pulse, sticky flag.
        step(cf, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 21, 1, 1, 1, 1), "conf_first");
        step(24'd0, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 21, 0, 0, 1, 1), "conf_after");

        // 300 more conflict cycles: counter saturates at 255.
        for (int k = 1; k <= 300; k++)
            step(cf, 1'b0, 1'b0,
                 mk(32'hDEAD_BEEF, 21, 1, 1, 1, (k + 1 > 255) ? 255 : k + 1), "conf_sat");
        step(24'd0, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 21, 0, 0, 1, 255), "sat_hold");
        step(24'd0, 1'b1, 1'b0, mk(32'hDEAD_BEEF, 21, 0, 0, 0, 0), "errclr");
        step(24'd0, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 21, 0, 0, 0, 0), "idle_after_clr");

        // err_clr coincident with a conflict: conflict wins.
        step(cf, 1'b0, 1'b0, mk(32'hDEAD_BEEF, 21, 1, 1, 1, 1), "conf_again");
        step(cf, 1'b1, 1'b0, mk(32'hDEAD_BEEF, 21, 1, 1, 1, 1), "errclr_vs_conf");
        step(24'd0, 1'b1, 1'b0, mk(32'hDEAD_BEEF, 21, 0, 0, 0, 0), "errclr2");

        // DRIVE -> FAULT with R3 + LO.
        step(24'd1 << SRC_R3, 1'b0, 1'b0, mk(32'hA5, 3, 1, 0, 0, 0), "drive_r3");
        step((24'd1 << SRC_R3) | (24'd1 << SRC_LO), 1'b0, 1'b0,
             mk(slot_val(SRC_LO), 17, 1, 1, 1, 1), "drive_to_fault");

        // clear mid-transfer (and while in FAULT), then PC reappears.
        step(24'd1 << SRC_PC, 1'b0, 1'b0, mk(32'h40, 20, 1, 0, 1, 1), "pc_in_fault");
        step(24'd1 << SRC_PC, 1'b0, 1'b1, mk(32'h0, 0, 0, 0, 0, 0), "clear_mid");
        step(24'd1 << SRC_PC, 1'b0, 1'b0, mk(32'h40, 20, 1, 0, 0, 0), "pc_after_clear");
        step(24'd0, 1'b0, 1'b0, mk(32'h40, 20, 0, 0, 0, 0), "pc_hold");

        for (int k = 0; k < 10 && exp_q.size() != 0; k++)
            @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
